// File: rtl/logic_unit_n.sv
// logic_unit_n: multi-mode bitwise logic unit that processes a WIDTH-bit
// operand pair SLICE bits per clock, LSB slice first. Operands enter through
// a valid/ready handshake, the result plus registered zero/parity flags leave
// through a second one. At most one operation is in flight at a time.
module logic_unit_n #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             parity
);

    localparam int N    = WIDTH / SLICE;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    // Refuse to elaborate when the operand does not split into whole slices.
    generate
        if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("logic_unit_n: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [2:0]        op_q;
    logic [IDXW-1:0]   idx_q;
    logic [WIDTH-1:0]  result_q;
    logic [WIDTH-1:0]  result_d;
    logic              zero_q, parity_q;
    logic [WIDTH-1:0]  func_full;
    logic              accept;
    logic              running;
    logic              last_slice;

    assign accept     = in_valid && (state_q == S_IDLE);
    assign running    = (state_q == S_RUN);
    assign last_slice = (idx_q == IDXW'(N - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: accept in IDLE, walk the slices, hold until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)   state_d = S_RUN;
            S_RUN:   if (last_slice) state_d = S_DONE;
            S_DONE:  if (out_ready)  state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Full-width logic function of the latched operands; the operations are
    // purely bitwise, so each slice simply picks its own bits out of this.
    always_comb begin
        func_full = '0;
        case (op_q)
            3'b000:  func_full = a_q & b_q;
            3'b001:  func_full = a_q | b_q;
            3'b010:  func_full = a_q ^ b_q;
            3'b011:  func_full = ~(a_q | b_q);
            3'b100:  func_full = ~(a_q & b_q);
            3'b101:  func_full = ~(a_q ^ b_q);
            3'b110:  func_full = a_q & ~b_q;
            default: func_full = a_q;
        endcase
    end

    // Per-slice next value: cleared on accept so uncomputed slices read 0,
    // written only on the cycle its index comes up, otherwise held.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign result_d[gi*SLICE +: SLICE] =
                accept                             ? '0 :
                (running && idx_q == IDXW'(gi))    ? func_full[gi*SLICE +: SLICE] :
                                                     result_q[gi*SLICE +: SLICE];
        end
    endgenerate

    // Datapath registers: operand capture, slice index, result and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            result_q <= result_d;
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                op_q  <= op;
                idx_q <= '0;
            end else if (running) begin
                idx_q <= last_slice ? '0 : idx_q + IDXW'(1);
                // Flags come from the complete result, including the slice
                // being written on this final edge.
                if (last_slice) begin
                    zero_q   <= (result_d == '0);
                    parity_q <= ^result_d;
                end
            end
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out       = result_q;
    assign zero      = zero_q;
    assign parity    = parity_q;

endmodule

// File: tb/tb_logic_unit_n.sv
// tb_logic_unit_n: directed checks of logic_unit_n in three configurations
// (8/4, 16/4, 8/8) driven as a linear sequence from one initial block.
module tb_logic_unit_n;

    logic clk;
    logic rst_n;

    // WIDTH=8, SLICE=4 instance
    logic       in_valid8, in_ready8, out_valid8, out_ready8, zero8, parity8;
    logic [2:0] op8;
    logic [7:0] a8, b8, out8;

    // WIDTH=16, SLICE=4 instance
    logic        in_valid16, in_ready16, out_valid16, out_ready16, zero16, parity16;
    logic [2:0]  op16;
    logic [15:0] a16, b16, out16;

    // WIDTH=8, SLICE=8 instance
    logic       in_valid88, in_ready88, out_valid88, out_ready88, zero88, parity88;
    logic [2:0] op88;
    logic [7:0] a88, b88, out88;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q8[$];

    logic_unit_n #(.WIDTH(8), .SLICE(4)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .op(op8), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out(out8),
        .zero(zero8), .parity(parity8)
    );

    logic_unit_n #(.WIDTH(16), .SLICE(4)) u16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16), .op(op16), .a(a16), .b(b16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out(out16),
        .zero(zero16), .parity(parity16)
    );

    logic_unit_n #(.WIDTH(8), .SLICE(8)) u88 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid88), .in_ready(in_ready88), .op(op88), .a(a88), .b(b88),
        .out_valid(out_valid88), .out_ready(out_ready88), .out(out88),
        .zero(zero88), .parity(parity88)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference for the eight logic operations.
    function automatic logic [7:0] ref8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return x ^ y;
            3'b011:  return ~(x | y);
            3'b100:  return ~(x & y);
            3'b101:  return ~(x ^ y);
            3'b110:  return x & ~y;
            default: return x;
        endcase
    endfunction

    // One full operation on the 8/4 instance with out_ready held high.
    task automatic run8(input string tag, input logic [2:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] eo, input logic ez,
                        input logic ep);
        int lat;
        out_ready8 = 1'b1;
        op8 = o; a8 = x; b8 = y; in_valid8 = 1'b1;
        chk({tag, "/in_ready_idle"}, 32'(in_ready8), 32'd1);
        tick();
        in_valid8 = 1'b0;
        a8 = ~x; b8 = ~y; op8 = o + 3'd1;
        chk({tag, "/in_ready_busy"}, 32'(in_ready8), 32'd0);
        lat = 0;
        while (!out_valid8 && lat < 10) begin
            tick();
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), 32'd2);
        chk({tag, "/out"}, 32'(out8), 32'(eo));
        chk({tag, "/zero"}, 32'(zero8), 32'(ez));
        chk({tag, "/parity"}, 32'(parity8), 32'(ep));
        tick();
        chk({tag, "/out_valid_after"}, 32'(out_valid8), 32'd0);
        chk({tag, "/in_ready_after"}, 32'(in_ready8), 32'd1);
        $display("txn %s op=%0d a=%02h b=%02h out=%02h zero=%0b parity=%0b lat=%0d",
                 tag, o, x, y, out8, zero8, parity8, lat);
    endtask

    initial begin
        int lat;
        int acc;
        int res;
        int last_acc;
        logic [7:0] ra, rb, re;
        logic [2:0] ro;
        bit took;

        rst_n = 1'b0;
        in_valid8 = 0;  out_ready8 = 1;  op8 = 0;  a8 = 0;  b8 = 0;
        in_valid16 = 0; out_ready16 = 1; op16 = 0; a16 = 0; b16 = 0;
        in_valid88 = 0; out_ready88 = 1; op88 = 0; a88 = 0; b88 = 0;

        // Reset state
        repeat (3) tick();
        chk("rst/out_valid", 32'(out_valid8), 32'd0);
        chk("rst/out", 32'(out8), 32'd0);
        chk("rst/zero", 32'(zero8), 32'd0);
        chk("rst/parity", 32'(parity8), 32'd0);
        chk("rst/in_ready", 32'(in_ready8), 32'd1);
        chk("rst/in_ready16", 32'(in_ready16), 32'd1);
        chk("rst/in_ready88", 32'(in_ready88), 32'd1);
        $display("txn reset checked");
        rst_n = 1'b1;
        tick();

        // OR with out_ready low at first: latency and in_ready timing
        out_ready8 = 1'b0;
        op8 = 3'b001; a8 = 8'hA5; b8 = 8'h0F; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        chk("or/in_ready_e0", 32'(in_ready8), 32'd0);
        chk("or/out_valid_e0", 32'(out_valid8), 32'd0);
        tick();
        chk("or/out_valid_e1", 32'(out_valid8), 32'd0);
        chk("or/in_ready_e1", 32'(in_ready8), 32'd0);
        tick();
        chk("or/out_valid_e2", 32'(out_valid8), 32'd1);
        chk("or/out", 32'(out8), 32'h0000_00AF);
        chk("or/zero", 32'(zero8), 32'd0);
        chk("or/parity", 32'(parity8), 32'd0);
        chk("or/in_ready_done", 32'(in_ready8), 32'd0);
        out_ready8 = 1'b1;
        tick();
        chk("or/out_valid_hs", 32'(out_valid8), 32'd0);
        chk("or/in_ready_hs", 32'(in_ready8), 32'd1);
        $display("txn or a=a5 b=0f out=%02h", out8);

        // Directed vectors
        run8("nor", 3'b011, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
        run8("xor", 3'b010, 8'h3C, 8'h0F, 8'h33, 1'b0, 1'b0);
        run8("pass", 3'b111, 8'h07, 8'hC3, 8'h07, 1'b0, 1'b1);

        // Sweep of all eight ops against the reference
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            re = ref8(3'(i), ra, rb);
            run8($sformatf("sweep%0d", i), 3'(i), ra, rb, re, (re == 8'h00), ^re);
        end

        // Backpressure: AND 0xCC,0xAA -> 0x88 held while the consumer stalls
        out_ready8 = 1'b0;
        op8 = 3'b000; a8 = 8'hCC; b8 = 8'hAA; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick();
        tick();
        chk("bp/out_valid", 32'(out_valid8), 32'd1);
        for (int i = 0; i < 5; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            op8 = 3'($urandom);
            in_valid8 = ((i % 2) == 0);
            tick();
            chk("bp/hold_valid", 32'(out_valid8), 32'd1);
            chk("bp/hold_ready", 32'(in_ready8), 32'd0);
            chk("bp/hold_out", 32'(out8), 32'h0000_0088);
            chk("bp/hold_zero", 32'(zero8), 32'd0);
            chk("bp/hold_parity", 32'(parity8), 32'd0);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        tick();
        chk("bp/release_valid", 32'(out_valid8), 32'd0);
        chk("bp/release_ready", 32'(in_ready8), 32'd1);
        tick();
        chk("bp/no_second_op", 32'(in_ready8), 32'd1);
        $display("txn backpressure out=88 held 5 cycles");

        // Reset mid-RUN, after slice 0 of AND 0xFF,0x0F has been written
        op8 = 3'b000; a8 = 8'hFF; b8 = 8'h0F; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick();
        chk("midrst/partial_out", 32'(out8), 32'h0000_000F);
        chk("midrst/partial_valid", 32'(out_valid8), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst/out_valid", 32'(out_valid8), 32'd0);
        chk("midrst/out", 32'(out8), 32'd0);
        chk("midrst/zero", 32'(zero8), 32'd0);
        chk("midrst/parity", 32'(parity8), 32'd0);
        chk("midrst/in_ready", 32'(in_ready8), 32'd1);
        $display("txn reset mid-run");
        tick();
        rst_n = 1'b1;
        tick();
        run8("post_rst_and", 3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);

        // Back-to-back with in_valid and out_ready held high
        out_ready8 = 1'b1;
        in_valid8 = 1'b1;
        op8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        acc = 0; res = 0; last_acc = -1;
        for (int c = 0; c < 16; c++) begin
            took = 1'b0;
            if (out_valid8) begin
                res++;
                if (q8.size() > 0) begin
                    re = q8.pop_front();
                    chk("b2b/out", 32'(out8), 32'(re));
                    $display("txn b2b result out=%02h exp=%02h", out8, re);
                end else begin
                    chk("b2b/unexpected_result", 32'(q8.size()), 32'd1);
                end
            end
            if (in_ready8) begin
                q8.push_back(ref8(op8, a8, b8));
                if (last_acc >= 0) chk("b2b/interval", 32'(c - last_acc), 32'd4);
                last_acc = c;
                acc++;
                took = 1'b1;
            end
            tick();
            if (took) begin
                op8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
            end
        end
        in_valid8 = 1'b0;
        chk("b2b/accepts", 32'(acc), 32'd4);
        chk("b2b/results", 32'(res), 32'd4);
        chk("b2b/pending", 32'(q8.size()), 32'd0);

        // WIDTH=16, SLICE=4: ANDN 0x1234,0x00FF -> 0x1200, latency 4
        op16 = 3'b110; a16 = 16'h1234; b16 = 16'h00FF; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        a16 = 16'hFFFF; op16 = 3'b001;
        lat = 0;
        while (!out_valid16 && lat < 12) begin
            tick();
            lat++;
            if (lat == 3) chk("w16/partial_out", 32'(out16), 32'h0000_0200);
        end
        chk("w16/latency", 32'(lat), 32'd4);
        chk("w16/out", 32'(out16), 32'h0000_1200);
        chk("w16/zero", 32'(zero16), 32'd0);
        chk("w16/parity", 32'(parity16), 32'd0);
        $display("txn w16 andn out=%04h lat=%0d", out16, lat);
        tick();
        chk("w16/in_ready_after", 32'(in_ready16), 32'd1);

        // WIDTH=8, SLICE=8: XNOR 0xAA,0x55 -> 0x00, latency 1
        op88 = 3'b101; a88 = 8'hAA; b88 = 8'h55; in_valid88 = 1'b1;
        tick();
        in_valid88 = 1'b0;
        lat = 0;
        while (!out_valid88 && lat < 12) begin
            tick();
            lat++;
        end
        chk("w8s8/latency", 32'(lat), 32'd1);
        chk("w8s8/out", 32'(out88), 32'd0);
        chk("w8s8/zero", 32'(zero88), 32'd1);
        chk("w8s8/parity", 32'(parity88), 32'd0);
        $display("txn w8s8 xnor out=%02h lat=%0d", out88, lat);
        tick();
        chk("w8s8/in_ready_after", 32'(in_ready88), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
